// File: rtl/motion_executor.sv
// motion_executor: turns one-step front/turn commands from the navigation FSM
// into a timed H-bridge drive burst followed by an optional brake interval.
//
// Handshake: front/turn are level commands sampled on posedge clk only while
// the block is idle (busy=0). A command seen in IDLE is accepted on that edge,
// acknowledged by a one-cycle cmd_ack, and any command presented while busy=1
// is dropped. The navigation FSM is not back-pressured.
module motion_executor #(
  parameter int unsigned FWD_CYCLES   = 50000,
  parameter int unsigned TURN_CYCLES  = 30000,
  parameter int unsigned BRAKE_CYCLES = 5000,
  parameter int          CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       front,
  input  logic       turn,
  output logic [1:0] motor_l,
  output logic [1:0] motor_r,
  output logic       busy,
  output logic       cmd_ack,
  output logic       move_done,
  output logic [7:0] move_cnt,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    TURN  = 2'd2,
    BRAKE = 2'd3
  } state_t;

  localparam logic [1:0] M_STOP = 2'b00;
  localparam logic [1:0] M_FWD  = 2'b01;
  localparam logic [1:0] M_REV  = 2'b10;

  // Durations truncated to the counter width; the counter is loaded with N-1
  localparam logic [CNT_W-1:0] FWD_N   = CNT_W'(FWD_CYCLES);
  localparam logic [CNT_W-1:0] TURN_N  = CNT_W'(TURN_CYCLES);
  localparam logic [CNT_W-1:0] BRAKE_N = CNT_W'(BRAKE_CYCLES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] FWD_LD   = FWD_N - ONE;
  localparam logic [CNT_W-1:0] TURN_LD  = TURN_N - ONE;
  localparam logic [CNT_W-1:0] BRAKE_LD = BRAKE_N - ONE;
  localparam bit               HAS_BRAKE = (BRAKE_N != '0);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  assign state_dbg = state;

  // Single FSM: state, duration counter and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      motor_l   <= M_STOP;
      motor_r   <= M_STOP;
      busy      <= 1'b0;
      cmd_ack   <= 1'b0;
      move_done <= 1'b0;
      move_cnt  <= 8'd0;
    end else begin
      cmd_ack   <= 1'b0;
      move_done <= 1'b0;
      case (state)
        IDLE: begin
          // turn wins over front: a blocked front is the safe outcome
          if (turn) begin
            state   <= TURN;
            cnt     <= TURN_LD;
            motor_l <= M_FWD;
            motor_r <= M_REV;
            busy    <= 1'b1;
            cmd_ack <= 1'b1;
          end else if (front) begin
            state   <= FWD;
            cnt     <= FWD_LD;
            motor_l <= M_FWD;
            motor_r <= M_FWD;
            busy    <= 1'b1;
            cmd_ack <= 1'b1;
          end else begin
            motor_l <= M_STOP;
            motor_r <= M_STOP;
            busy    <= 1'b0;
          end
        end
        FWD, TURN: begin
          if (cnt != '0) begin
            cnt <= cnt - ONE;
          end else if (HAS_BRAKE) begin
            state   <= BRAKE;
            cnt     <= BRAKE_LD;
            motor_l <= M_STOP;
            motor_r <= M_STOP;
          end else begin
            state     <= IDLE;
            motor_l   <= M_STOP;
            motor_r   <= M_STOP;
            busy      <= 1'b0;
            move_done <= 1'b1;
            move_cnt  <= move_cnt + 8'd1;
          end
        end
        BRAKE: begin
          if (cnt != '0) begin
            cnt <= cnt - ONE;
          end else begin
            state     <= IDLE;
            busy      <= 1'b0;
            move_done <= 1'b1;
            move_cnt  <= move_cnt + 8'd1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          motor_l <= M_STOP;
          motor_r <= M_STOP;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motion_executor.sv
// tb_motion_executor: table-driven vectors plus hand-written multi-cycle
// sequences for motion_executor (FWD=4, TURN=6, BRAKE=2; second copy BRAKE=0).
module tb_motion_executor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       front, turn;
  logic [1:0] motor_l, motor_r, state_dbg;
  logic       busy, cmd_ack, move_done;
  logic [7:0] move_cnt;

  logic       front0, turn0;
  logic [1:0] motor_l0, motor_r0, state_dbg0;
  logic       busy0, cmd_ack0, move_done0;
  logic [7:0] move_cnt0;

  motion_executor #(.FWD_CYCLES(4), .TURN_CYCLES(6), .BRAKE_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .front(front), .turn(turn),
    .motor_l(motor_l), .motor_r(motor_r), .busy(busy), .cmd_ack(cmd_ack),
    .move_done(move_done), .move_cnt(move_cnt), .state_dbg(state_dbg)
  );

  motion_executor #(.FWD_CYCLES(4), .TURN_CYCLES(6), .BRAKE_CYCLES(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .front(front0), .turn(turn0),
    .motor_l(motor_l0), .motor_r(motor_r0), .busy(busy0), .cmd_ack(cmd_ack0),
    .move_done(move_done0), .move_cnt(move_cnt0), .state_dbg(state_dbg0)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Motor encoding invariant on both instances, sampled away from the edge
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if (motor_l == 2'b11 || motor_r == 2'b11 || (motor_l == 2'b10 && motor_r == 2'b10) ||
          motor_l0 == 2'b11 || motor_r0 == 2'b11 || (motor_l0 == 2'b10 && motor_r0 == 2'b10)) begin
        bad++;
        $display("FAIL motor_inv: got %b/%b %b/%b expected no 11 and no double reverse",
                 motor_l, motor_r, motor_l0, motor_r0);
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic       f, t;
    logic [1:0] ml, mr;
    logic       busy, ack, done;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[32];

  function automatic vec_t mk(logic f, logic t, logic [1:0] ml, logic [1:0] mr,
                              logic b, logic a, logic d, logic [7:0] c);
    vec_t v;
    v.f = f; v.t = t; v.ml = ml; v.mr = mr; v.busy = b; v.ack = a; v.done = d; v.cnt = c;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_main(input string tag, input logic [1:0] ml, input logic [1:0] mr,
                             input logic b, input logic a, input logic d, input logic [7:0] c);
    chk({tag, ".motor_l"}, 32'(motor_l), 32'(ml));
    chk({tag, ".motor_r"}, 32'(motor_r), 32'(mr));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".cmd_ack"}, 32'(cmd_ack), 32'(a));
    chk({tag, ".move_done"}, 32'(move_done), 32'(d));
    chk({tag, ".move_cnt"}, 32'(move_cnt), 32'(c));
  endtask

  initial begin
    int done_seen;
    int cyc;

    front = 0; turn = 0; front0 = 0; turn0 = 0;

    // Test 1: front pulse, 4 FWD + 2 BRAKE + IDLE with move_done
    vecs[0] = mk(1, 0, 2'b01, 2'b01, 1, 1, 0, 0);
    for (int i = 1; i <= 3; i++) vecs[i] = mk(0, 0, 2'b01, 2'b01, 1, 0, 0, 0);
    vecs[4] = mk(0, 0, 2'b00, 2'b00, 1, 0, 0, 0);
    vecs[5] = mk(0, 0, 2'b00, 2'b00, 1, 0, 0, 0);
    vecs[6] = mk(0, 0, 2'b00, 2'b00, 0, 0, 1, 1);
    vecs[7] = mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 1);
    // Test 2: front+turn together -> TURN for 6, brake 2
    vecs[8] = mk(1, 1, 2'b01, 2'b10, 1, 1, 0, 1);
    for (int i = 9; i <= 13; i++) vecs[i] = mk(0, 0, 2'b01, 2'b10, 1, 0, 0, 1);
    vecs[14] = mk(0, 0, 2'b00, 2'b00, 1, 0, 0, 1);
    vecs[15] = mk(0, 0, 2'b00, 2'b00, 1, 0, 0, 1);
    vecs[16] = mk(0, 0, 2'b00, 2'b00, 0, 0, 1, 2);
    // Test 3: front held -> back-to-back every 7 cycles; turn toggled mid-FWD
    vecs[17] = mk(1, 0, 2'b01, 2'b01, 1, 1, 0, 2);
    vecs[18] = mk(1, 0, 2'b01, 2'b01, 1, 0, 0, 2);
    vecs[19] = mk(1, 1, 2'b01, 2'b01, 1, 0, 0, 2);
    vecs[20] = mk(1, 0, 2'b01, 2'b01, 1, 0, 0, 2);
    vecs[21] = mk(1, 0, 2'b00, 2'b00, 1, 0, 0, 2);
    vecs[22] = mk(1, 0, 2'b00, 2'b00, 1, 0, 0, 2);
    vecs[23] = mk(1, 0, 2'b00, 2'b00, 0, 0, 1, 3);
    vecs[24] = mk(1, 0, 2'b01, 2'b01, 1, 1, 0, 3);
    for (int i = 25; i <= 27; i++) vecs[i] = mk(0, 0, 2'b01, 2'b01, 1, 0, 0, 3);
    vecs[28] = mk(0, 0, 2'b00, 2'b00, 1, 0, 0, 3);
    vecs[29] = mk(0, 0, 2'b00, 2'b00, 1, 0, 0, 3);
    vecs[30] = mk(0, 0, 2'b00, 2'b00, 0, 0, 1, 4);
    vecs[31] = mk(0, 0, 2'b00, 2'b00, 0, 0, 0, 4);

    // Reset state, checked with no clock edge since reset is asynchronous
    #1;
    expect_main("reset", 2'b00, 2'b00, 0, 0, 0, 0);
    chk("reset.state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    expect_main("post_reset", 2'b00, 2'b00, 0, 0, 0, 0);

    // Table-driven portion
    for (int i = 0; i < 32; i++) begin
      front = vecs[i].f;
      turn  = vecs[i].t;
      step();
      expect_main($sformatf("vec%0d", i), vecs[i].ml, vecs[i].mr,
                  vecs[i].busy, vecs[i].ack, vecs[i].done, vecs[i].cnt);
    end
    front = 0; turn = 0;

    // Test 5: BRAKE_CYCLES=0 -> straight back to IDLE after drive
    front0 = 1;
    step();
    front0 = 0;
    chk("nobrk.ack", 32'(cmd_ack0), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      chk($sformatf("nobrk.drive%0d", i), 32'({motor_l0, motor_r0}), 32'b0101);
      chk($sformatf("nobrk.busy%0d", i), 32'(busy0), 32'd1);
    end
    step();
    chk("nobrk.motors", 32'({motor_l0, motor_r0}), 32'b0000);
    chk("nobrk.busy", 32'(busy0), 32'd0);
    chk("nobrk.done", 32'(move_done0), 32'd1);
    chk("nobrk.cnt", 32'(move_cnt0), 32'd1);
    step();
    chk("nobrk.done_pulse", 32'(move_done0), 32'd0);

    // Test 4: reset two cycles into TURN
    turn = 1;
    step();
    turn = 0;
    step();
    chk("rst_mid.turning", 32'({motor_l, motor_r}), 32'b0110);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid.motors", 32'({motor_l, motor_r}), 32'b0000);
    chk("rst_mid.busy", 32'(busy), 32'd0);
    chk("rst_mid.cnt", 32'(move_cnt), 32'd0);
    chk("rst_mid.cnt0", 32'(move_cnt0), 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0 || i == 9) begin
        expect_main($sformatf("rst_idle%0d", i), 2'b00, 2'b00, 0, 0, 0, 0);
        chk($sformatf("rst_idle%0d.state", i), 32'(state_dbg), 32'd0);
      end
    end

    // Test 6: 256 back-to-back moves -> move_cnt wraps to 0
    exp_q.push_back(32'd255);
    exp_q.push_back(32'd0);
    done_seen = 0;
    cyc = 0;
    front = 1;
    while (done_seen < 256 && cyc < 3000) begin
      step();
      cyc++;
      if (move_done) begin
        done_seen++;
        if (done_seen >= 255) chk($sformatf("wrap.cnt%0d", done_seen), 32'(move_cnt), exp_q.pop_front());
      end
    end
    front = 0;
    chk("wrap.moves", 32'(done_seen), 32'd256);
    chk("wrap.cycles", 32'(cyc), 32'd1792);
    chk("wrap.queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (8) step();
    chk("wrap.final_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
